// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the LSU-to-RAM request/valid master.
//   oplen_e     - access size encoding carried on req_oplen / mem_oplen
//   lsu_state_e - transaction sequencer states
//   req_is_bad  - decides whether a request is rejected without touching memory
package mem_pkg;

   typedef enum logic [1:0] {
      OP_BYTE    = 2'b00,
      OP_HALF    = 2'b01,
      OP_WORD    = 2'b10,
      OP_ILLEGAL = 2'b11
   } oplen_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_WAIT  = 3'd1,
      ST_RMW_WAIT = 3'd2,
      ST_WR_WAIT  = 3'd3,
      ST_RESP     = 3'd4
   } lsu_state_e;

   localparam logic [31:0] GPIO_ADDR_DEFAULT = 32'hFFFF_FFFF;
   localparam int unsigned TIMEOUT_DEFAULT   = 16;

   // The GPIO register is a single word: it is exempt from the word alignment
   // rule, but any sub-word access to it is rejected so it is never merged.
   function automatic logic req_is_bad(input logic [31:0] addr,
                                       input logic [1:0]  oplen,
                                       input logic [31:0] gpio_addr);
      logic is_gpio;
      is_gpio = (addr == gpio_addr);
      case (oplen)
         OP_BYTE: return is_gpio;
         OP_HALF: return addr[0] | is_gpio;
         OP_WORD: return (addr[1:0] != 2'b00) && !is_gpio;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering between core and word RAM.
//   rd_word_i    - word returned by the RAM
//   byte_sel_i   - low address bits of the access
//   oplen_i      - access size
//   unsigned_i   - zero-extend (1) or sign-extend (0) sub-word loads
//   wdata_i      - low half of the store data (only bytes/halves are merged)
//   load_data_o  - extracted and extended load result
//   store_word_o - rd_word_i with the store bytes written into their lanes
module lsu_lane_align
   import mem_pkg::*;
(
   input  logic [31:0] rd_word_i,
   input  logic [1:0]  byte_sel_i,
   input  oplen_e      oplen_i,
   input  logic        unsigned_i,
   input  logic [15:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_word_o
);

   logic [4:0]  byte_shift;
   logic [4:0]  half_shift;
   logic [7:0]  lane8;
   logic [15:0] lane16;

   assign byte_shift = {byte_sel_i, 3'b000};
   assign half_shift = {byte_sel_i[1], 4'b0000};

   always_comb begin
      // NOTE: every output gets a value before the case so no path can leave
      // one unassigned, which would infer a latch.
      load_data_o  = rd_word_i;
      store_word_o = rd_word_i;
      lane8        = 8'(rd_word_i >> byte_shift);
      lane16       = 16'(rd_word_i >> half_shift);
      case (oplen_i)
         OP_BYTE: begin
            load_data_o  = {{24{~unsigned_i & lane8[7]}}, lane8};
            store_word_o = (rd_word_i & ~(32'h0000_00FF << byte_shift))
                         | ({24'h0, wdata_i[7:0]} << byte_shift);
         end
         OP_HALF: begin
            load_data_o  = {{16{~unsigned_i & lane16[15]}}, lane16};
            store_word_o = (rd_word_i & ~(32'h0000_FFFF << half_shift))
                         | ({16'h0, wdata_i} << half_shift);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: turns core load/store requests into one-shot RAM accesses.
//   Core side : req_valid/req_ready handshake, req_addr/we/oplen/unsigned/wdata,
//               resp_valid pulse with resp_rdata/resp_err (no backpressure).
//   RAM side  : mem_enable pulse with mem_addr/oplen/we/data, completion on
//               mem_valid with mem_result one or more cycles later.
//   Sub-word stores are read-modify-write; a missing mem_valid ends the
//   transaction with an error after TIMEOUT_CYCLES wait cycles.
module lsu_mem_master
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter logic [31:0] GPIO_ADDR      = GPIO_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [1:0]  req_oplen,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_enable,
   output logic [31:0] mem_addr,
   output logic [1:0]  mem_oplen,
   output logic        mem_we,
   output logic [31:0] mem_data,
   input  logic        mem_valid,
   input  logic [31:0] mem_result
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   lsu_state_e       state_q, state_d;
   logic [1:0]       lane_q, lane_d;
   oplen_e           oplen_q, oplen_d;
   logic             uns_q, uns_d;
   logic [15:0]      wdata_q, wdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             req_ready_q, req_ready_d;
   logic             resp_valid_q, resp_valid_d;
   logic [31:0]      resp_rdata_q, resp_rdata_d;
   logic             resp_err_q, resp_err_d;
   logic             mem_enable_q, mem_enable_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [1:0]       mem_oplen_q, mem_oplen_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_data_q, mem_data_d;

   logic             accept;
   logic             bad_req;
   logic             sub_word_store;
   logic             timeout_hit;
   logic [31:0]      load_data;
   logic [31:0]      store_word;

   assign accept         = req_valid && req_ready_q;
   assign bad_req        = req_is_bad(req_addr, req_oplen, GPIO_ADDR);
   assign sub_word_store = req_we && (req_oplen != OP_WORD);
   assign timeout_hit    = (cnt_q == CNT_LAST);

   lsu_lane_align u_lane_align (
      .rd_word_i    (mem_result),
      .byte_sel_i   (lane_q),
      .oplen_i      (oplen_q),
      .unsigned_i   (uns_q),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data),
      .store_word_o (store_word)
   );

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: registered state is assigned with <= so every flop samples the
      // pre-edge values, independent of the order of statements.
      if (!rst) begin
         state_q      <= ST_IDLE;
         lane_q       <= 2'b00;
         oplen_q      <= OP_BYTE;
         uns_q        <= 1'b0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         mem_enable_q <= 1'b0;
         mem_addr_q   <= '0;
         mem_oplen_q  <= 2'b00;
         mem_we_q     <= 1'b0;
         mem_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         oplen_q      <= oplen_d;
         uns_q        <= uns_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_enable_q <= mem_enable_d;
         mem_addr_q   <= mem_addr_d;
         mem_oplen_q  <= mem_oplen_d;
         mem_we_q     <= mem_we_d;
         mem_data_q   <= mem_data_d;
      end
   end

   // Next-state logic. mem_valid is only looked at in the wait states, so a
   // stale completion arriving in IDLE or RESP has no effect.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (bad_req)             state_d = ST_RESP;
               else if (!req_we)        state_d = ST_RD_WAIT;
               else if (sub_word_store) state_d = ST_RMW_WAIT;
               else                     state_d = ST_WR_WAIT;
            end
         end
         ST_RD_WAIT,
         ST_WR_WAIT: begin
            if (mem_valid || timeout_hit) state_d = ST_RESP;
         end
         ST_RMW_WAIT: begin
            if (mem_valid)        state_d = ST_WR_WAIT;
            else if (timeout_hit) state_d = ST_RESP;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      lane_d       = lane_q;
      oplen_d      = oplen_q;
      uns_d        = uns_q;
      wdata_d      = wdata_q;
      mem_enable_d = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_oplen_d  = mem_oplen_q;
      mem_we_d     = mem_we_q;
      mem_data_d   = mem_data_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      resp_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               lane_d  = req_addr[1:0];
               oplen_d = oplen_e'(req_oplen);
               uns_d   = req_unsigned;
               wdata_d = req_wdata[15:0];
               if (bad_req) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  mem_enable_d = 1'b1;
                  mem_addr_d   = (req_addr == GPIO_ADDR) ? req_addr : {req_addr[31:2], 2'b00};
                  mem_oplen_d  = req_oplen;
                  // Sub-word stores start with a read of the containing word.
                  mem_we_d     = req_we && !sub_word_store;
                  mem_data_d   = mem_we_d ? req_wdata : 32'h0;
               end
            end
         end
         ST_RD_WAIT: begin
            if (mem_valid) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = load_data;
            end else if (timeout_hit) begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end
         end
         ST_RMW_WAIT: begin
            if (mem_valid) begin
               mem_enable_d = 1'b1;
               mem_we_d     = 1'b1;
               mem_data_d   = store_word;
            end else if (timeout_hit) begin
               // The merged write is dropped: RAM contents stay as they were.
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end
         end
         ST_WR_WAIT: begin
            if (mem_valid) begin
               resp_valid_d = 1'b1;
            end else if (timeout_hit) begin
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end
         end
         ST_RESP: mem_we_d = 1'b0;
         default: ;
      endcase

      req_ready_d = (state_d == ST_IDLE);

      // Counts wait cycles since the most recent enable pulse.
      if (mem_enable_d)
         cnt_d = '0;
      else if (state_q inside {ST_RD_WAIT, ST_RMW_WAIT, ST_WR_WAIT})
         cnt_d = cnt_q + CNT_W'(1);
      else
         cnt_d = '0;
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign mem_enable = mem_enable_q;
   assign mem_addr   = mem_addr_q;
   assign mem_oplen  = mem_oplen_q;
   assign mem_we     = mem_we_q;
   assign mem_data   = mem_data_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: drives load/store transactions into lsu_mem_master, with
// a word RAM + GPIO register responder on the memory side, and compares every
// cycle against a transaction-level model (expected response cycle/value and
// the ordered list of RAM accesses each request must produce).
module tb_lsu_mem_master;
   import mem_pkg::*;

   localparam int          TO   = 16;
   localparam logic [31:0] GPIO = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        req_we = 1'b0;
   logic [1:0]  req_oplen = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_enable;
   logic [31:0] mem_addr;
   logic [1:0]  mem_oplen;
   logic        mem_we;
   logic [31:0] mem_data;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_result = '0;

   always #5 clk = ~clk;

   lsu_mem_master #(.TIMEOUT_CYCLES(TO), .GPIO_ADDR(GPIO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_we       (req_we),
      .req_oplen    (req_oplen),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_enable   (mem_enable),
      .mem_addr     (mem_addr),
      .mem_oplen    (mem_oplen),
      .mem_we       (mem_we),
      .mem_data     (mem_data),
      .mem_valid    (mem_valid),
      .mem_result   (mem_result)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- RAM / GPIO responder ----------------
   logic [31:0] ram [16];
   logic [31:0] gpio_reg = '0;
   bit          mute = 1'b0;
   bit          dev_pend = 1'b0;
   logic [31:0] dev_data = '0;

   always @(negedge clk) begin
      if (rst && mem_enable && !mute) begin
         dev_pend = 1'b1;
         if (mem_addr == GPIO) begin
            if (mem_we) gpio_reg = mem_data;
            dev_data = gpio_reg;
         end else begin
            if (mem_we) ram[mem_addr[5:2]] = mem_data;
            dev_data = ram[mem_addr[5:2]];
         end
      end
   end

   always @(posedge clk) begin
      #1;
      mem_valid  = dev_pend;
      mem_result = dev_pend ? dev_data : 32'h0;
      dev_pend   = 1'b0;
   end

   // ---------------- Reference model ----------------
   logic [31:0] mm [16];
   logic [31:0] mgpio = '0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [1:0]  op;
      logic [31:0] data;
   } acc_t;

   acc_t        acc_q[$];
   bit          exp_active = 1'b0;
   int          exp_cyc = 0;
   logic [31:0] exp_rdata = '0;
   logic        exp_err = 1'b0;
   int          en_cnt = 0;
   bit          prev_en = 1'b0;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;
   int          last_en = 0;
   int          last_resp_cyc = 0;
   int          last_acc_cyc = 0;
   acc_t        cur;

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] addr,
                                              input logic [1:0] op, input logic uns);
      logic [31:0] v;
      case (op)
         2'b00: begin
            v = (w >> (8 * addr[1:0])) & 32'h0000_00FF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
         end
         2'b01: begin
            v = (w >> (16 * addr[1])) & 32'h0000_FFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] addr,
                                               input logic [1:0] op, input logic [31:0] wd);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
      if (op == 2'b00) begin
         b[addr[1:0]] = wd[7:0];
      end else begin
         b[{addr[1], 1'b0}] = wd[7:0];
         b[{addr[1], 1'b1}] = wd[15:8];
      end
      return {b[3], b[2], b[1], b[0]};
   endfunction

   // ---------------- Per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst) begin
         check("req_ready", {31'h0, req_ready}, {31'h0, !exp_active});
         if (mem_enable) begin
            en_cnt++;
            check("mem_enable_back_to_back", {31'h0, prev_en}, 32'h0);
            if (acc_q.size() == 0) begin
               check("mem_enable_unexpected", {31'h0, mem_enable}, 32'h0);
            end else begin
               cur = acc_q.pop_front();
               check("mem_addr", mem_addr, cur.addr);
               check("mem_we", {31'h0, mem_we}, {31'h0, cur.we});
               check("mem_oplen", {30'h0, mem_oplen}, {30'h0, cur.op});
               if (cur.we) check("mem_data", mem_data, cur.data);
            end
         end
         prev_en = mem_enable;
         if (resp_valid) last_resp_cyc = cyc;
         if (exp_active && cyc == exp_cyc) begin
            check("resp_valid", {31'h0, resp_valid}, 32'h1);
            check("resp_rdata", resp_rdata, exp_rdata);
            check("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
            check("accesses_outstanding", 32'(acc_q.size()), 32'h0);
            last_rdata = resp_rdata;
            last_err   = resp_err;
            last_en    = en_cnt;
            exp_active = 1'b0;
         end else begin
            check("resp_valid_idle", {31'h0, resp_valid}, 32'h0);
         end
      end
   end

   // ---------------- Driver ----------------
   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("req_ready_wait", {31'h0, req_ready}, 32'h1);
   endtask

   task automatic do_req(input logic we, input logic [1:0] op, input logic [31:0] addr,
                         input logic uns, input logic [31:0] wd, input bit mt);
      int          lat;
      int          n;
      logic        err;
      logic [31:0] w, rd, nw, waddr;
      acc_t        accs[$];

      wait_ready();
      mute         = mt;
      req_valid    = 1'b1;
      req_we       = we;
      req_oplen    = op;
      req_addr     = addr;
      req_unsigned = uns;
      req_wdata    = wd;
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      last_acc_cyc = cyc;
      en_cnt       = 0;

      err = (op == 2'b11) || (op == 2'b01 && addr[0]) ||
            (op == 2'b10 && addr[1:0] != 2'b00 && addr != GPIO) ||
            (addr == GPIO && op != 2'b10);
      waddr = (addr == GPIO) ? addr : (addr & ~32'h3);
      w     = (addr == GPIO) ? mgpio : mm[addr[5:2]];
      rd    = 32'h0;
      nw    = w;
      lat   = 1;
      if (!err) begin
         if (!we) begin
            rd  = model_load(w, addr, op, uns);
            accs.push_back('{waddr, 1'b0, op, 32'h0});
            lat = 3;
         end else if (op == 2'b10) begin
            nw  = wd;
            accs.push_back('{waddr, 1'b1, op, wd});
            lat = 3;
         end else begin
            nw  = model_merge(w, addr, op, wd);
            accs.push_back('{waddr, 1'b0, op, 32'h0});
            accs.push_back('{waddr, 1'b1, op, nw});
            lat = 5;
         end
         if (mt) begin
            // RAM never answers: only the first access goes out.
            while (accs.size() > 1) void'(accs.pop_back());
            rd  = 32'h0;
            err = 1'b1;
            lat = 1 + TO;
         end else if (we) begin
            if (addr == GPIO) mgpio = nw;
            else mm[addr[5:2]] = nw;
         end
      end

      foreach (accs[i]) acc_q.push_back(accs[i]);
      exp_rdata  = rd;
      exp_err    = err;
      exp_cyc    = last_acc_cyc + lat - 1;
      exp_active = 1'b1;

      n = 0;
      while (exp_active && n < lat + 10) begin
         @(posedge clk);
         n++;
      end
      if (exp_active) begin
         check("response_wait", {31'h0, exp_active}, 32'h0);
         exp_active = 1'b0;
         acc_q.delete();
      end
      mute = 1'b0;
   endtask

   task automatic pin(input string nm, input logic [31:0] rd, input logic err,
                      input int lat, input int en);
      check({nm, "_rdata"}, last_rdata, rd);
      check({nm, "_err"}, {31'h0, last_err}, {31'h0, err});
      check({nm, "_latency"}, 32'(last_resp_cyc - last_acc_cyc + 1), 32'(lat));
      check({nm, "_enables"}, 32'(last_en), 32'(en));
   endtask

   // Reset asserted while the RMW read is outstanding: no response, no write.
   task automatic reset_mid_rmw();
      wait_ready();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_oplen = 2'b00;
      req_addr  = 32'd5;
      req_wdata = 32'h0000_00EE;
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      last_acc_cyc = cyc;
      en_cnt       = 0;
      acc_q.push_back('{32'd4, 1'b0, 2'b00, 32'h0});
      exp_rdata  = 32'h0;
      exp_err    = 1'b0;
      exp_cyc    = last_acc_cyc + 4;
      exp_active = 1'b1;
      @(negedge clk);
      #2;
      rst        = 1'b0;
      exp_active = 1'b0;
      acc_q.delete();
      #1;
      check("rst_req_ready", {31'h0, req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_resp_err", {31'h0, resp_err}, 32'h0);
      check("rst_mem_enable", {31'h0, mem_enable}, 32'h0);
      check("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_data", mem_data, 32'h0);
      check("rst_mem_oplen", {30'h0, mem_oplen}, 32'h0);
      #1;
      rst = 1'b1;
      // The stale mem_valid lands while idle; the compare process flags any
      // response or enable that appears here.
      repeat (5) @(posedge clk);
   endtask

   // ---------------- Main sequence ----------------
   initial begin
      logic [31:0] ra;
      logic [1:0]  rop;

      for (int i = 0; i < 16; i++) begin
         ram[i] = $urandom;
         mm[i]  = ram[i];
      end
      ram[1] = 32'h8899_AABB;
      mm[1]  = 32'h8899_AABB;

      repeat (3) @(posedge clk);
      #1;
      check("reset_req_ready", {31'h0, req_ready}, 32'h1);
      check("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
      check("reset_resp_rdata", resp_rdata, 32'h0);
      check("reset_mem_enable", {31'h0, mem_enable}, 32'h0);
      check("reset_mem_addr", mem_addr, 32'h0);
      check("reset_mem_data", mem_data, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      do_req(1'b0, 2'b10, 32'd4, 1'b0, 32'h0, 1'b0);
      pin("ld_word4", 32'h8899_AABB, 1'b0, 3, 1);
      do_req(1'b0, 2'b00, 32'd5, 1'b0, 32'h0, 1'b0);
      pin("ld_byte5_s", 32'hFFFF_FFAA, 1'b0, 3, 1);
      do_req(1'b0, 2'b00, 32'd5, 1'b1, 32'h0, 1'b0);
      pin("ld_byte5_u", 32'h0000_00AA, 1'b0, 3, 1);
      do_req(1'b0, 2'b01, 32'd6, 1'b0, 32'h0, 1'b0);
      pin("ld_half6_s", 32'hFFFF_8899, 1'b0, 3, 1);
      do_req(1'b1, 2'b00, 32'd6, 1'b0, 32'h0000_0011, 1'b0);
      pin("st_byte6", 32'h0, 1'b0, 5, 2);
      check("st_byte6_ram", ram[1], 32'h8811_AABB);
      do_req(1'b0, 2'b10, 32'd4, 1'b0, 32'h0, 1'b0);
      pin("ld_after_st", 32'h8811_AABB, 1'b0, 3, 1);

      do_req(1'b0, 2'b01, 32'd3, 1'b0, 32'h0, 1'b0);
      pin("err_half3", 32'h0, 1'b1, 1, 0);
      do_req(1'b1, 2'b10, 32'd2, 1'b0, 32'h1234_5678, 1'b0);
      pin("err_word2", 32'h0, 1'b1, 1, 0);
      do_req(1'b0, 2'b11, 32'd8, 1'b0, 32'h0, 1'b0);
      pin("err_op11", 32'h0, 1'b1, 1, 0);

      do_req(1'b1, 2'b10, GPIO, 1'b0, 32'h0000_0005, 1'b0);
      pin("gpio_st", 32'h0, 1'b0, 3, 1);
      do_req(1'b0, 2'b10, GPIO, 1'b0, 32'h0, 1'b0);
      pin("gpio_ld", 32'h0000_0005, 1'b0, 3, 1);

      do_req(1'b0, 2'b10, 32'd8, 1'b0, 32'h0, 1'b1);
      pin("timeout_ld", 32'h0, 1'b1, 1 + TO, 1);
      do_req(1'b1, 2'b01, 32'd8, 1'b0, 32'h0000_BEEF, 1'b1);
      pin("timeout_rmw", 32'h0, 1'b1, 1 + TO, 1);

      reset_mid_rmw();
      do_req(1'b0, 2'b10, 32'd4, 1'b0, 32'h0, 1'b0);
      pin("ld_after_abort", 32'h8811_AABB, 1'b0, 3, 1);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            ra  = GPIO;
            rop = 2'b10;
         end else begin
            ra  = 32'($urandom_range(0, 63));
            rop = 2'($urandom_range(0, 3));
         end
         do_req(1'($urandom_range(0, 1)), rop, ra, 1'($urandom_range(0, 1)),
                $urandom, ($urandom_range(0, 24) == 0));
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
